// File: rtl/alu_exec_unit_if.sv
// Valid/ready request and result bundle between register-read and the execute unit.
// master = upstream issue/consumer side, slave = alu_exec_unit.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      aluop;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output in_valid, aluop, funct3, funct7, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, aluop, funct3, funct7, src_a, src_b, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Self-timed execute unit: 1-cycle integer/compare ops, MUL_LAT-cycle multiplier, and
// a restoring radix-2 divider built only when ALU_EXEC_DIV_EN is defined.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rstn,
    alu_exec_unit_if.slave     bus
);
    localparam int SW  = $clog2(XLEN);
    localparam int MCW = $clog2(MUL_LAT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef ALU_EXEC_DIV_EN
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam int         DCW     = $clog2(XLEN + 1);
`endif

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [1:0]      state;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic [MCW-1:0]  mul_cnt;
    logic [XLEN-1:0] mul_hold;

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [SW-1:0]   shamt;
    logic            is_imm;
    logic            f7_ok;
    logic            accept;

    logic [XLEN-1:0] sc_res;
    logic            sc_ill;
    logic            start_mul;
    logic            slt_s;
    logic            slt_u;
    logic            taken;

    logic              mul_a_sx;
    logic              mul_b_sx;
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_sel;

    assign a      = bus.src_a;
    assign b      = bus.src_b;
    assign f3     = bus.funct3;
    assign f7     = bus.funct7;
    assign shamt  = bus.src_b[SW-1:0];
    assign is_imm = bus.aluop[0];
    assign f7_ok  = is_imm || (f7 == F7_ZERO);
    assign slt_s  = $signed(a) < $signed(b);
    assign slt_u  = a < b;

    assign bus.in_ready  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // One 2*XLEN multiplier covers all four variants by choosing how each operand is extended.
    assign mul_a_sx = (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10);
    assign mul_b_sx = (f3[1:0] == 2'b01);
    assign ext_a    = {{XLEN{mul_a_sx & a[XLEN-1]}}, a};
    assign ext_b    = {{XLEN{mul_b_sx & b[XLEN-1]}}, b};
    assign prod     = ext_a * ext_b;
    assign mul_sel  = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef ALU_EXEC_DIV_EN
    logic            start_div;
    logic            div_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_divisor;
    logic [DCW-1:0]  div_cnt;
    logic            div_neg_q;
    logic            div_neg_r;
    logic            div_is_rem;
    logic [XLEN:0]   div_shift;
    logic            div_take;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    assign div_signed = !f3[0];
    assign a_neg      = div_signed && a[XLEN-1];
    assign b_neg      = div_signed && b[XLEN-1];
    assign abs_a      = a_neg ? -a : a;
    assign abs_b      = b_neg ? -b : b;

    // Partial remainder never reaches the divisor, so the subtraction fits in XLEN bits.
    assign div_shift = {div_rem, div_quo[XLEN-1]};
    assign div_take  = div_shift >= {1'b0, div_divisor};
    assign rem_next  = div_take ? (div_shift[XLEN-1:0] - div_divisor) : div_shift[XLEN-1:0];
    assign quo_next  = {div_quo[XLEN-2:0], div_take};
`endif

    always_comb begin
        sc_res    = '0;
        sc_ill    = 1'b0;
        start_mul = 1'b0;
        taken     = 1'b0;
`ifdef ALU_EXEC_DIV_EN
        start_div = 1'b0;
`endif
        case (bus.aluop)
            3'b000: sc_res = a + b;
            3'b001: sc_res = a - b;
            3'b100, 3'b101: begin
                case (f3)
                    3'b000: begin
                        if (f7_ok)                sc_res = a + b;
                        else if (f7 == F7_ALT)    sc_res = a - b;
                        else                      sc_ill = 1'b1;
                    end
                    3'b001: begin
                        if (f7 == F7_ZERO)        sc_res = a << shamt;
                        else                      sc_ill = 1'b1;
                    end
                    3'b010: begin
                        if (f7_ok)                sc_res = {{(XLEN-1){1'b0}}, slt_s};
                        else                      sc_ill = 1'b1;
                    end
                    3'b011: begin
                        if (f7_ok)                sc_res = {{(XLEN-1){1'b0}}, slt_u};
                        else                      sc_ill = 1'b1;
                    end
                    3'b100: begin
                        if (f7_ok)                sc_res = a ^ b;
                        else                      sc_ill = 1'b1;
                    end
                    3'b101: begin
                        if (f7 == F7_ZERO)        sc_res = a >> shamt;
                        else if (f7 == F7_ALT)    sc_res = $unsigned($signed(a) >>> shamt);
                        else                      sc_ill = 1'b1;
                    end
                    3'b110: begin
                        if (f7_ok)                sc_res = a | b;
                        else                      sc_ill = 1'b1;
                    end
                    default: begin
                        if (f7_ok)                sc_res = a & b;
                        else                      sc_ill = 1'b1;
                    end
                endcase
            end
            3'b110: begin
                if (!f3[2]) begin
                    start_mul = 1'b1;
                end
`ifdef ALU_EXEC_DIV_EN
                // Divide-by-zero and signed overflow resolve immediately without iterating.
                else if (b == '0) begin
                    sc_res = f3[1] ? a : '1;
                end else if (div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
                    sc_res = f3[1] ? '0 : a;
                end else begin
                    start_div = 1'b1;
                end
`else
                else begin
                    sc_ill = 1'b1;
                end
`endif
            end
            3'b111: begin
                case (f3)
                    3'b000:  taken = (a == b);
                    3'b001:  taken = (a != b);
                    3'b100:  taken = slt_s;
                    3'b101:  taken = !slt_s;
                    3'b110:  taken = slt_u;
                    3'b111:  taken = !slt_u;
                    default: sc_ill = 1'b1;
                endcase
                sc_res = {{(XLEN-1){1'b0}}, taken};
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // Result register is only written when nothing is held, so a stalled result stays put.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            mul_cnt     <= '0;
            mul_hold    <= '0;
`ifdef ALU_EXEC_DIV_EN
            div_rem     <= '0;
            div_quo     <= '0;
            div_divisor <= '0;
            div_cnt     <= '0;
            div_neg_q   <= 1'b0;
            div_neg_r   <= 1'b0;
            div_is_rem  <= 1'b0;
`endif
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (start_mul) begin
                            if (MUL_LAT == 1) begin
                                result_q    <= mul_sel;
                                illegal_q   <= 1'b0;
                                out_valid_q <= 1'b1;
                            end else begin
                                mul_hold <= mul_sel;
                                mul_cnt  <= MCW'(MUL_LAT - 2);
                                state    <= ST_MUL;
                            end
                        end
`ifdef ALU_EXEC_DIV_EN
                        else if (start_div) begin
                            div_rem     <= '0;
                            div_quo     <= abs_a;
                            div_divisor <= abs_b;
                            div_cnt     <= DCW'(XLEN);
                            div_neg_q   <= a_neg ^ b_neg;
                            div_neg_r   <= a_neg;
                            div_is_rem  <= f3[1];
                            state       <= ST_DIV;
                        end
`endif
                        else begin
                            result_q    <= sc_res;
                            illegal_q   <= sc_ill;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_cnt == '0) begin
                        result_q    <= mul_hold;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
`ifdef ALU_EXEC_DIV_EN
                ST_DIV: begin
                    div_rem <= rem_next;
                    div_quo <= quo_next;
                    div_cnt <= div_cnt - 1'b1;
                    if (div_cnt == DCW'(1)) begin
                        if (div_is_rem) result_q <= div_neg_r ? -rem_next : rem_next;
                        else            result_q <= div_neg_q ? -quo_next : quo_next;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32, MUL_LAT=3); divider expectations follow ALU_EXEC_DIV_EN.
module tb_alu_exec_unit;
    logic clk;
    logic rstn;
    int   compared   = 0;
    int   mismatched = 0;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32), .MUL_LAT(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not terminate");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present one op, wait for accept, then count edges (accept edge = 1) until out_valid.
    task automatic apply_stimulus(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output logic busy_ready);
        int waits = 0;
        bus.aluop    = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waits < 100) begin
            @(posedge clk); #1;
            waits++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.src_a    = ~a;
        bus.src_b    = ~b;
        bus.funct3   = ~f3;
        lat          = 1;
        busy_ready   = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            busy_ready = busy_ready | bus.in_ready;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        int   lat;
        logic busy_ready;
        apply_stimulus(op, f3, f7, a, b, lat, busy_ready);
        check_output({tag, "/result"}, bus.result, exp_res);
        check_output({tag, "/illegal"}, {31'b0, bus.illegal}, {31'b0, exp_ill});
        check_output({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        if (exp_lat > 1) check_output({tag, "/in_ready_busy"}, {31'b0, busy_ready}, 32'd0);
    endtask

    function automatic logic [31:0] model(input int k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            0:       return a + b;
            1:       return a - b;
            2:       return a ^ b;
            3:       return a | b;
            4:       return a & b;
            5:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6:       return (a < b) ? 32'd1 : 32'd0;
            default: return a << b[4:0];
        endcase
    endfunction

    initial begin
        int          lat;
        logic        busy_ready;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] expv;
        int          k;

        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.aluop     = 3'b000;
        bus.funct3    = 3'b000;
        bus.funct7    = 7'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b1;

        #1;
        check_output("rst/out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_output("rst/result", bus.result, 32'd0);
        check_output("rst/illegal", {31'b0, bus.illegal}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_output("rst/in_ready", {31'b0, bus.in_ready}, 32'd1);

        $display("[TB] single-cycle integer ops");
        run_op("sra",      3'b100, 3'b101, 7'h20, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1);
        run_op("add",      3'b000, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       1'b0, 1);
        run_op("sub",      3'b001, 3'b000, 7'h00, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1);
        run_op("srli",     3'b101, 3'b101, 7'h00, 32'h000000F0, 32'd4,        32'h0000000F, 1'b0, 1);
        run_op("addi_f7",  3'b101, 3'b000, 7'h20, 32'd10,       32'hFFFFFFFF, 32'd9,        1'b0, 1);
        run_op("r_badf7",  3'b100, 3'b000, 7'h01, 32'd10,       32'd3,        32'd0,        1'b1, 1);
        run_op("slli_bad", 3'b101, 3'b001, 7'h20, 32'd1,        32'd3,        32'd0,        1'b1, 1);
        run_op("slt",      3'b100, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
        run_op("sltu",     3'b100, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        run_op("aluop010", 3'b010, 3'b000, 7'h00, 32'd1,        32'd2,        32'd0,        1'b1, 1);

        $display("[TB] multiplier with stalled consumer");
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_op("mulhu", 3'b110, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_output("hold/out_valid", {31'b0, bus.out_valid}, 32'd1);
            check_output("hold/result", bus.result, 32'hFFFFFFFE);
            check_output("hold/in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("hold/released", {31'b0, bus.out_valid}, 32'd0);

        run_op("mul",    3'b110, 3'b000, 7'h01, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 3);
        run_op("mulh",   3'b110, 3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 3);
        run_op("mulhsu", 3'b110, 3'b010, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3);

        $display("[TB] divide ops");
`ifdef ALU_EXEC_DIV_EN
        run_op("div",      3'b110, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
        run_op("rem",      3'b110, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
        run_op("remu",     3'b110, 3'b111, 7'h01, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        run_op("divu_z",   3'b110, 3'b101, 7'h01, 32'd123,      32'd0,        32'hFFFFFFFF, 1'b0, 1);
        run_op("rem_z",    3'b110, 3'b110, 7'h01, 32'd123,      32'd0,        32'd123,      1'b0, 1);
        run_op("div_ovf",  3'b110, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
`else
        run_op("div_off",  3'b110, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        32'd0,        1'b1, 1);
        run_op("remu_off", 3'b110, 3'b111, 7'h01, 32'd100,      32'd0,        32'd0,        1'b1, 1);
`endif

        $display("[TB] branch compares");
        run_op("blt",    3'b111, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 1);
        run_op("bltu",   3'b111, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1);
        run_op("b010",   3'b111, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1);
        run_op("beq",    3'b111, 3'b000, 7'h00, 32'd5,        32'd5, 32'd1, 1'b0, 1);
        run_op("bge",    3'b111, 3'b101, 7'h00, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1);
        run_op("bgeu",   3'b111, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 1);

        $display("[TB] back-to-back random single-cycle ops");
        for (int i = 0; i < 20; i++) begin
            k  = int'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case (k)
                0:       begin bus.aluop = 3'b000; bus.funct3 = 3'b000; end
                1:       begin bus.aluop = 3'b001; bus.funct3 = 3'b000; end
                2:       begin bus.aluop = 3'b100; bus.funct3 = 3'b100; end
                3:       begin bus.aluop = 3'b100; bus.funct3 = 3'b110; end
                4:       begin bus.aluop = 3'b100; bus.funct3 = 3'b111; end
                5:       begin bus.aluop = 3'b100; bus.funct3 = 3'b010; end
                6:       begin bus.aluop = 3'b100; bus.funct3 = 3'b011; end
                default: begin bus.aluop = 3'b101; bus.funct3 = 3'b001; end
            endcase
            bus.funct7   = 7'h00;
            bus.src_a    = ra;
            bus.src_b    = rb;
            bus.in_valid = 1'b1;
            expv         = model(k, ra, rb);
            check_output("b2b/in_ready", {31'b0, bus.in_ready}, 32'd1);
            @(posedge clk); #1;
            check_output("b2b/out_valid", {31'b0, bus.out_valid}, 32'd1);
            check_output("b2b/result", bus.result, expv);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        $display("[TB] reset during a long operation");
`ifdef ALU_EXEC_DIV_EN
        apply_stimulus(3'b110, 3'b100, 7'h01, 32'd1000, 32'd3, lat, busy_ready);
        check_output("pre_reset/latency", 32'(lat), 32'd33);
        @(posedge clk); #1;
        bus.aluop    = 3'b110;
        bus.funct3   = 3'b100;
        bus.src_a    = 32'd1000;
        bus.src_b    = 32'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
`else
        @(posedge clk); #1;
        bus.aluop    = 3'b110;
        bus.funct3   = 3'b011;
        bus.src_a    = 32'hFFFFFFFF;
        bus.src_b    = 32'hFFFFFFFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
`endif
        rstn = 1'b0;
        #1;
        check_output("abort/out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_output("abort/result", bus.result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_output("abort/in_ready", {31'b0, bus.in_ready}, 32'd1);
        check_output("abort/result_after", bus.result, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check_output("abort/no_stale", {31'b0, bus.out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
